// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor control path: timer state encodings,
// the time-setting constants produced by the time-select FSM, and the default unit length.
package motor_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } timer_state_e;

  localparam logic [4:0] TIME_0  = 5'd0;
  localparam logic [4:0] TIME_10 = 5'd10;
  localparam logic [4:0] TIME_20 = 5'd20;
  localparam logic [4:0] TIME_30 = 5'd30;

  // 1 s per unit at a 100 MHz system clock.
  localparam int UNIT_CYCLES_DEFAULT = 100_000_000;

endpackage

// File: rtl/unit_tick_gen.sv
// Prescaler that flags the last cycle of each time unit while enabled.
// i_clear has priority and restarts the unit from zero.
module unit_tick_gen
  import motor_ctrl_pkg::*;
#(
  parameter int UNIT_CYCLES = UNIT_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int             CW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // The tick marks the cycle whose edge completes the unit, so the owner acts on that same edge.
  assign o_tick = i_enable && (r_count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/motor_off_timer.sv
// Counts the selected run time down while the motor runs and requests
// motor shut-off at zero; all outputs come straight from registers.
module motor_off_timer
  import motor_ctrl_pkg::*;
#(
  parameter int UNIT_CYCLES = UNIT_CYCLES_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_timeSet,
  input  logic       i_motorOn,
  output logic [4:0] o_remain,
  output logic       o_running,
  output logic       o_timeout,
  output logic       o_offRequest
);

  timer_state_e r_state, w_state_nxt;
  logic [4:0]   r_remain, w_remain_nxt;
  logic [4:0]   r_set_latch, w_set_latch_nxt;
  logic         r_timeout, w_timeout_nxt;
  logic         r_running, r_off_req;
  logic         w_tick, w_clear, w_enable, w_set_changed;

  assign w_set_changed = (i_timeSet != r_set_latch);
  assign w_enable      = (r_state == COUNT);
  // Any load, reload or exit from COUNT restarts the unit from zero.
  assign w_clear       = (r_state != COUNT) || !i_motorOn || w_set_changed;

  unit_tick_gen #(.UNIT_CYCLES(UNIT_CYCLES)) u_tick (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_tick   (w_tick)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt     = r_state;
    w_remain_nxt    = r_remain;
    w_set_latch_nxt = r_set_latch;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_remain_nxt = '0;
        if (i_motorOn && (i_timeSet != TIME_0)) begin
          w_state_nxt     = COUNT;
          w_remain_nxt    = i_timeSet;
          w_set_latch_nxt = i_timeSet;
        end
      end
      COUNT: begin
        if (!i_motorOn) begin
          w_state_nxt  = IDLE;
          w_remain_nxt = '0;
        end else if (w_set_changed && (i_timeSet == TIME_0)) begin
          w_state_nxt  = IDLE;
          w_remain_nxt = '0;
        end else if (w_set_changed) begin
          w_remain_nxt    = i_timeSet;
          w_set_latch_nxt = i_timeSet;
        end else if (w_tick) begin
          if (r_remain == 5'd1) begin
            w_state_nxt   = EXPIRED;
            w_remain_nxt  = '0;
            w_timeout_nxt = 1'b1;
          end else begin
            w_remain_nxt = r_remain - 5'd1;
          end
        end
      end
      EXPIRED: begin
        w_remain_nxt = '0;
        if (!i_motorOn) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_remain_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_remain    <= '0;
      r_set_latch <= '0;
      r_timeout   <= 1'b0;
      r_running   <= 1'b0;
      r_off_req   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remain    <= w_remain_nxt;
      r_set_latch <= w_set_latch_nxt;
      r_timeout   <= w_timeout_nxt;
      r_running   <= (w_state_nxt == COUNT);
      r_off_req   <= (w_state_nxt == EXPIRED);
    end
  end

  assign o_remain     = r_remain;
  assign o_running    = r_running;
  assign o_timeout    = r_timeout;
  assign o_offRequest = r_off_req;

endmodule

// File: tb/tb_motor_off_timer.sv
// Directed self-checking bench for motor_off_timer with a 4-cycle time unit.
module tb_motor_off_timer;

  localparam int UC = 4;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [4:0] i_timeSet;
  logic       i_motorOn;
  logic [4:0] o_remain;
  logic       o_running;
  logic       o_timeout;
  logic       o_offRequest;

  int   checks = 0;
  int   errors = 0;
  logic seen_timeout;

  always #5 i_clk = ~i_clk;

  motor_off_timer #(.UNIT_CYCLES(UC)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_timeSet    (i_timeSet),
    .i_motorOn    (i_motorOn),
    .o_remain     (o_remain),
    .o_running    (o_running),
    .o_timeout    (o_timeout),
    .o_offRequest (o_offRequest)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges; sample 1 time unit after each edge and latch any timeout pulse.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      if (o_timeout === 1'b1) seen_timeout = 1'b1;
    end
  endtask

  initial begin
    seen_timeout = 1'b0;
    i_reset   = 1'b1;
    i_motorOn = 1'b0;
    i_timeSet = 5'd0;
    run(2);
    i_reset = 1'b0;
    run(1);
    check("rst_remain",  o_remain,     0);
    check("rst_running", o_running,    0);
    check("rst_timeout", o_timeout,    0);
    check("rst_offreq",  o_offRequest, 0);

    // Full countdown of 10 units.
    i_motorOn = 1'b1; i_timeSet = 5'd10; seen_timeout = 1'b0;
    run(1);
    check("load_remain",  o_remain,  10);
    check("load_running", o_running, 1);
    run(3);
    check("pre_dec_remain", o_remain, 10);
    run(1);
    check("first_dec_remain", o_remain, 9);
    run(35);
    check("last_unit_remain", o_remain, 1);
    check("no_early_timeout", seen_timeout, 0);
    run(1);
    check("expire_timeout", o_timeout,    1);
    check("expire_offreq",  o_offRequest, 1);
    check("expire_remain",  o_remain,     0);
    check("expire_running", o_running,    0);
    run(1);
    check("timeout_one_cycle", o_timeout,    0);
    check("offreq_held",       o_offRequest, 1);
    i_motorOn = 1'b0;
    run(1);
    check("motor_off_offreq", o_offRequest, 0);

    // Asynchronous reset in the middle of a count.
    i_motorOn = 1'b1; i_timeSet = 5'd10;
    run(6);
    check("pre_reset_running", o_running, 1);
    i_reset = 1'b1;
    #1;
    check("async_rst_remain",  o_remain,  0);
    check("async_rst_running", o_running, 0);
    run(2);
    i_motorOn = 1'b0; i_timeSet = 5'd0;
    i_reset = 1'b0; seen_timeout = 1'b0;
    run(50);
    check("post_rst_no_timeout", seen_timeout, 0);
    check("post_rst_remain",     o_remain,     0);

    // Reload 20 -> 10 at remain 15.
    i_motorOn = 1'b1; i_timeSet = 5'd20;
    run(1);
    check("reload_load", o_remain, 20);
    run(20);
    check("reload_at15", o_remain, 15);
    i_timeSet = 5'd10;
    run(1);
    check("reload_remain", o_remain, 10);
    run(3);
    check("reload_no_dec", o_remain, 10);
    run(1);
    check("reload_dec", o_remain, 9);

    // Cancel 30 -> 0 while counting.
    i_timeSet = 5'd30;
    run(1);
    check("cancel_load", o_remain, 30);
    run(6);
    check("cancel_pre", o_remain, 29);
    i_timeSet = 5'd0; seen_timeout = 1'b0;
    run(1);
    check("cancel_running", o_running, 0);
    check("cancel_remain",  o_remain,  0);
    run(130);
    check("cancel_no_timeout", seen_timeout, 0);
    check("cancel_no_offreq",  o_offRequest, 0);

    // Motor off on the same edge as the final tick.
    i_timeSet = 5'd1;
    run(1);
    check("race_load", o_remain, 1);
    run(3);
    i_motorOn = 1'b0; seen_timeout = 1'b0;
    run(1);
    check("race_running", o_running, 0);
    check("race_remain",  o_remain,  0);
    run(10);
    check("race_no_timeout", seen_timeout, 0);

    // Setting changes are ignored once expired.
    i_motorOn = 1'b1; i_timeSet = 5'd2;
    run(1);
    check("hold_load", o_remain, 2);
    run(8);
    check("hold_timeout", o_timeout, 1);
    i_timeSet = 5'd20;
    run(1);
    check("hold_offreq",  o_offRequest, 1);
    check("hold_remain",  o_remain,     0);
    check("hold_running", o_running,    0);
    run(10);
    check("hold_offreq_late", o_offRequest, 1);
    check("hold_remain_late", o_remain,     0);
    i_motorOn = 1'b0;
    run(1);
    check("hold_release", o_offRequest, 0);

    // Start with zero setting, then a late non-zero setting; reload on the final tick.
    i_motorOn = 1'b1; i_timeSet = 5'd0;
    run(1);
    check("zero_set_idle", o_running, 0);
    i_timeSet = 5'd1;
    run(1);
    check("late_start_running", o_running, 1);
    check("late_start_remain",  o_remain,  1);
    run(3);
    i_timeSet = 5'd3; seen_timeout = 1'b0;
    run(1);
    check("final_tick_reload_remain", o_remain,     3);
    check("final_tick_reload_no_to",  seen_timeout, 0);
    run(12);
    check("final_tick_reload_expire", o_timeout, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
